// File: rtl/vsync_pkg.sv
// Shared types and default parameter values for the vsync frame sequencer.
package vsync_pkg;
  localparam int FRAME_CNT_W_DEF = 8;
  localparam int TIMEOUT_W_DEF   = 24;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int VSYNC_POL_DEF   = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;
endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the camera vsync into the clk domain and flags its active edge.
module vsync_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int VSYNC_POL   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_vsync,
  output logic o_edge
);
  localparam logic INACT = (VSYNC_POL == 0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_last;

  // Everything resets to the inactive level so release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{INACT}};
      r_prev <= INACT;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_vsync};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_last = r_sync[SYNC_STAGES-1];
  assign o_edge = (w_last != r_prev) && (w_last != INACT);
endmodule

// File: rtl/vsync_frame_seq.sv
// Captures a requested number of frames delimited by vsync edges, with an
// optional inter-edge timeout and abort.
module vsync_frame_seq
  import vsync_pkg::*;
#(
  parameter int FRAME_CNT_W = FRAME_CNT_W_DEF,
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int VSYNC_POL   = VSYNC_POL_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic [TIMEOUT_W-1:0]   timeout_cycles,
  output logic                   frame_active,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err
);
  state_e                 r_state;
  logic [FRAME_CNT_W-1:0] r_count;
  logic [TIMEOUT_W-1:0]   r_tmo_lim;
  logic [TIMEOUT_W-1:0]   r_tmo;
  logic                   w_edge;
  logic [TIMEOUT_W-1:0]   w_tmo_nxt;
  logic                   w_tmo_hit;
  logic                   w_last;

  vsync_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .VSYNC_POL   (VSYNC_POL)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_vsync (vsync),
    .o_edge  (w_edge)
  );

  // Timeout fires on the cycle the count reaches the limit, so a limit of N
  // ends the capture N cycles after the last clear.
  assign w_tmo_nxt = r_tmo + 1'b1;
  assign w_tmo_hit = (r_tmo_lim != '0) && (w_tmo_nxt == r_tmo_lim);
  assign w_last    = (frame_idx == r_count - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_tmo_lim    <= '0;
      r_tmo        <= '0;
      frame_active <= 1'b0;
      frame_start  <= 1'b0;
      frame_idx    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            timeout_err <= 1'b0;
            if (num_frames != '0) begin
              r_count   <= num_frames;
              r_tmo_lim <= timeout_cycles;
              r_tmo     <= '0;
              done      <= 1'b0;
              busy      <= 1'b1;
              r_state   <= ST_ARM;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_ARM, ST_CAPTURE: begin
          // Priority: abort, then edge, then timeout.
          if (abort) begin
            r_state      <= ST_IDLE;
            frame_active <= 1'b0;
            busy         <= 1'b0;
          end else if (w_edge) begin
            r_tmo <= '0;
            if (r_state == ST_ARM) begin
              r_state      <= ST_CAPTURE;
              frame_idx    <= '0;
              frame_active <= 1'b1;
              frame_start  <= 1'b1;
            end else if (w_last) begin
              r_state      <= ST_IDLE;
              frame_active <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else begin
              frame_idx   <= frame_idx + 1'b1;
              frame_start <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state      <= ST_IDLE;
            frame_active <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b1;
          end else begin
            r_tmo <= w_tmo_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vsync_frame_seq.sv
// Scoreboard bench: stimulus queues expected events, monitors pop and compare.
module tb_vsync_frame_seq;
  localparam int FW = 8;
  localparam int TW = 24;
  localparam int EV_FS = 0, EV_DONE = 1, EV_TMO = 2;

  typedef struct {
    int kind;
    int idx;
    int cyc;
  } ev_t;

  logic          clk = 1'b0, reset = 1'b1;
  logic          vsync = 1'b0, start = 1'b0, abort = 1'b0;
  logic [FW-1:0] num_frames = '0;
  logic [TW-1:0] timeout_cycles = '0;
  logic          frame_active, frame_start, busy, done, timeout_err;
  logic [FW-1:0] frame_idx;

  logic          vsync2 = 1'b1, start2 = 1'b0, abort2 = 1'b0;
  logic [FW-1:0] num2 = '0;
  logic [TW-1:0] tmo2 = '0;
  logic          frame_active2, frame_start2, busy2, done2, timeout_err2;
  logic [FW-1:0] frame_idx2;

  ev_t q1[$];
  ev_t q2[$];
  int  total = 0, bad = 0, cyc = 0, t0;
  logic pd1 = 1'b0, pt1 = 1'b0, pd2 = 1'b0;

  vsync_frame_seq #(.FRAME_CNT_W(FW), .TIMEOUT_W(TW), .SYNC_STAGES(2), .VSYNC_POL(1)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start), .abort(abort),
    .num_frames(num_frames), .timeout_cycles(timeout_cycles),
    .frame_active(frame_active), .frame_start(frame_start), .frame_idx(frame_idx),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  vsync_frame_seq #(.FRAME_CNT_W(FW), .TIMEOUT_W(TW), .SYNC_STAGES(2), .VSYNC_POL(0)) dut_neg (
    .clk(clk), .reset(reset), .vsync(vsync2), .start(start2), .abort(abort2),
    .num_frames(num2), .timeout_cycles(tmo2),
    .frame_active(frame_active2), .frame_start(frame_start2), .frame_idx(frame_idx2),
    .busy(busy2), .done(done2), .timeout_err(timeout_err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic ev_t mk(input int k, input int i, input int c);
    ev_t e;
    e.kind = k; e.idx = i; e.cyc = c;
    return e;
  endfunction

  task automatic got(input int n, input int k, input int idx, input int fa,
                     input int bz, input int dn, input int te);
    ev_t e;
    int  sz;
    sz = (n == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      total++; bad++;
      $display("FAIL d%0d_unexpected: got event %0d expected none", n, k);
    end else begin
      if (n == 1) e = q1.pop_front(); else e = q2.pop_front();
      chk($sformatf("d%0d_kind", n), k, e.kind);
      if (k == EV_FS) begin
        chk($sformatf("d%0d_idx", n), idx, e.idx);
        chk($sformatf("d%0d_active", n), fa, 1);
        chk($sformatf("d%0d_busy", n), bz, 1);
      end else begin
        chk($sformatf("d%0d_active_off", n), fa, 0);
        chk($sformatf("d%0d_busy_off", n), bz, 0);
        chk($sformatf("d%0d_done", n), dn, int'(k == EV_DONE));
        chk($sformatf("d%0d_tmo", n), te, int'(k == EV_TMO));
      end
      if (e.cyc >= 0) chk($sformatf("d%0d_cycle", n), cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_start) got(1, EV_FS, frame_idx, frame_active, busy, done, timeout_err);
      if (done && !pd1) got(1, EV_DONE, frame_idx, frame_active, busy, done, timeout_err);
      if (timeout_err && !pt1) got(1, EV_TMO, frame_idx, frame_active, busy, done, timeout_err);
      if (frame_start2) got(2, EV_FS, frame_idx2, frame_active2, busy2, done2, timeout_err2);
      if (done2 && !pd2) got(2, EV_DONE, frame_idx2, frame_active2, busy2, done2, timeout_err2);
    end
    pd1 = done; pt1 = timeout_err; pd2 = done2;
  end

  task automatic do_start(input int n, input int t, output int ts);
    @(negedge clk);
    num_frames = n[FW-1:0]; timeout_cycles = t[TW-1:0]; start = 1'b1;
    @(posedge clk); #1;
    ts = cyc; start = 1'b0;
  endtask

  task automatic rise();
    @(negedge clk); vsync = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); vsync = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic v2(input logic v);
    @(negedge clk); vsync2 = v;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    chk("rst_active", frame_active, 0); chk("rst_fstart", frame_start, 0);
    chk("rst_idx", frame_idx, 0);       chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);           chk("rst_tmo", timeout_err, 0);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);

    // Three frames, four rising edges
    q1.push_back(mk(EV_FS, 0, -1)); q1.push_back(mk(EV_FS, 1, -1));
    q1.push_back(mk(EV_FS, 2, -1)); q1.push_back(mk(EV_DONE, 0, -1));
    do_start(3, 0, t0);
    chk("a_busy", busy, 1);
    repeat (4) rise();

    // Timeout with no vsync activity
    do_start(2, 100, t0);
    q1.push_back(mk(EV_TMO, 0, t0 + 100));
    chk("b_done_clr", done, 0);
    repeat (110) @(posedge clk);

    // Zero-frame request completes at once without becoming busy
    do_start(0, 0, t0);
    q1.push_back(mk(EV_DONE, 0, t0));
    chk("c_busy0", busy, 0);
    repeat (4) begin
      @(negedge clk); chk("c_busy", busy, 0);
    end

    // Abort coincident with a detected edge in CAPTURE
    q1.push_back(mk(EV_FS, 0, -1));
    do_start(3, 0, t0);
    rise();
    @(negedge clk); vsync = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); vsync = 1'b1;
    @(posedge clk); @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("d_active", frame_active, 0); chk("d_busy", busy, 0);
    chk("d_done", done, 0);           chk("d_tmo", timeout_err, 0);
    chk("d_idx", frame_idx, 0);

    // Reset in the middle of frame 1 of 3, then a fresh capture
    q1.push_back(mk(EV_FS, 0, -1)); q1.push_back(mk(EV_FS, 1, -1));
    do_start(3, 0, t0);
    rise(); rise();
    @(negedge clk); reset = 1'b1; #1;
    chk("e_active", frame_active, 0); chk("e_fstart", frame_start, 0);
    chk("e_idx", frame_idx, 0);       chk("e_busy", busy, 0);
    chk("e_done", done, 0);           chk("e_tmo", timeout_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("e_done_after", done, 0); chk("e_busy_after", busy, 0);
    q1.push_back(mk(EV_FS, 0, -1)); q1.push_back(mk(EV_FS, 1, -1));
    q1.push_back(mk(EV_FS, 2, -1)); q1.push_back(mk(EV_DONE, 0, -1));
    do_start(3, 0, t0);
    repeat (4) rise();

    // Falling-edge polarity: rising edges must be ignored
    q2.push_back(mk(EV_FS, 0, -1)); q2.push_back(mk(EV_DONE, 0, -1));
    v2(1'b0);
    @(negedge clk); num2 = 8'd1; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    v2(1'b1); v2(1'b0); v2(1'b1); v2(1'b0);

    for (int i = 0; i < 50 && (q1.size() + q2.size()) != 0; i++) @(posedge clk);
    chk("queues_drained", q1.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
